systolic_row_feeder: RTL and testbench
======================================

// Module: systolic_row_feeder
// PURPOSE
//  Upstream stage of the GF systolic processor array. Accepts one command (op code + row count) and
//  then whole matrix rows as packed words. Emits per-column data/start/finish streams skewed by one
//  cycle per column, which is the diagonal timing the array's processing elements need. It drives
//  the array's top-edge data_in/start_in/finish_in/op_in inputs for MUL_MAT, EVAL and GAUSS passes.
// PARAMETERS
//  GF_BIT       4  field element width (4 or 8)
//  NUM_PROC_COL 3  array columns = elements per row word
//  OP_CODE_LEN  4  op code width
//  ROW_CNT_W    8  width of row count
// PORTS
//  clk         in   1                    clock; all logic on posedge
//  rst         in   1                    synchronous reset, active-high
//  cmd_valid   in   1                    command offered
//  cmd_ready   out  1                    command accepted when valid&ready
//  cmd_op      in   OP_CODE_LEN          op code for the pass
//  cmd_rows    in   ROW_CNT_W            rows in the pass (0 allowed)
//  row_valid   in   1                    row word offered
//  row_ready   out  1                    row accepted when valid&ready
//  row_data    in   NUM_PROC_COL*GF_BIT  element c at [c*GF_BIT +: GF_BIT]
//  arr_data    out  NUM_PROC_COL*GF_BIT  skewed element per column, registered
//  arr_start   out  NUM_PROC_COL         first-row flag per column, skewed
//  arr_finish  out  NUM_PROC_COL         last-row flag per column, skewed
//  arr_op      out  OP_CODE_LEN          op code of the current/last pass
//  busy        out  1                    state != IDLE
//  done        out  1                    1-cycle pass-complete pulse
//  underrun    out  1                    sticky: a row gap occurred in this pass
// BEHAVIOUR
//  Reset: state IDLE; all skew registers, arr_*, done, underrun, and the row counter are 0.
//   cmd_ready=1 and row_ready=0 after reset. Reset mid-pass aborts the pass. No done is produced.
//  FSM IDLE -> STREAM -> DRAIN -> IDLE.
//   IDLE: cmd_ready=1. On cmd handshake: latch cmd_op into arr_op (held until next cmd), clear
//    underrun, load remaining=cmd_rows, and go to STREAM. If cmd_rows==0, go to DRAIN instead.
//   STREAM: row_ready=1, cmd_ready=0. Each cycle consumes one row slot. With row_valid, the row
//    is accepted. Without row_valid, a zero row with start=finish=0 is injected, underrun<=1, and
//    the row count is NOT decremented. Rows must arrive back-to-back; the array has no stall.
//    After the last row is accepted, go to DRAIN.
//   DRAIN: row_ready=0. Runs NUM_PROC_COL cycles while the skew pipeline empties. Zero data and
//    zero flags enter behind the last row. Then go to IDLE and pulse done in the first IDLE cycle.
//  Latency: row k accepted at cycle T_k appears on column c at cycle T_k+1+c.
//   arr_start[c]=1 with row 0 and arr_finish[c]=1 with row cmd_rows-1. Both are 1 when cmd_rows==1.
//   done = T_last+NUM_PROC_COL+1. For cmd_rows==0: done 1+NUM_PROC_COL cycles after the cmd
//   handshake, and arr_* stays 0.
//  A cmd may be accepted in the same cycle done is high.
//  Skew: column c uses a c-stage shift register of {data,start,finish}. Column 0 has only the
//   output register. Cells outside active rows are 0.
//  Row counter is ROW_CNT_W bits and counts down, with no wrap: cmd_rows = 2^ROW_CNT_W-1 is legal.
// CONFIGURATION
//  FEEDER_FLUSH_EN defined: DRAIN is 2*NUM_PROC_COL cycles. The extra NUM_PROC_COL zero rows
//   (flags 0) push the final results out of the array's r registers.
//   done = T_last+2*NUM_PROC_COL+1.
//  Not defined: DRAIN length is NUM_PROC_COL as above.
// TESTING (GF_BIT=4, NUM_PROC_COL=3; cycle 0 = cmd handshake)
//  1 cmd_rows=2, rows 0x321 @1, 0x654 @2 ->
//    col0 1@2, 4@3; col1 2@3, 5@4; col2 3@4, 6@5.
//    start: col0@2, col1@3, col2@4. finish: col0@3, col1@4, col2@5. done@6.
//  2 cmd_rows=1, row 0xABC -> start&finish both 1: col0@2 (C), col1@3 (B), col2@4 (A). done@5.
//  3 cmd_rows=2, row_valid low @1, rows @2, @3 -> zero row (flags 0) on col0@2, start col0@3,
//    underrun=1 until next cmd, done@7.
//  4 rst high @3 during 4-row pass -> @4: IDLE, arr_*=0, cmd_ready=1, no done. New cmd works.
//  5 cmd_rows=0 -> row_ready never 1, arr_*=0, done@4, busy 1 on cycles 1-3.
//  6 FEEDER_FLUSH_EN, test 1 stimulus -> same outputs, arr_*=0 on cycles 6-8, done@9.

Source files
------------

// File: rtl/systolic_row_feeder.sv
// Row feeder for the GF systolic array: takes a command plus packed row words and emits per-column
// skewed data/start/finish streams. Define FEEDER_FLUSH_EN to double DRAIN and flush the r registers.
module systolic_row_feeder #(
    parameter int GF_BIT       = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int OP_CODE_LEN  = 4,
    parameter int ROW_CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [OP_CODE_LEN-1:0]         cmd_op,
    input  logic [ROW_CNT_W-1:0]           cmd_rows,
    input  logic                           row_valid,
    output logic                           row_ready,
    input  logic [NUM_PROC_COL*GF_BIT-1:0] row_data,
    output logic [NUM_PROC_COL*GF_BIT-1:0] arr_data,
    output logic [NUM_PROC_COL-1:0]        arr_start,
    output logic [NUM_PROC_COL-1:0]        arr_finish,
    output logic [OP_CODE_LEN-1:0]         arr_op,
    output logic                           busy,
    output logic                           done,
    output logic                           underrun
);

`ifdef FEEDER_FLUSH_EN
    localparam int DRAIN_LEN = 2 * NUM_PROC_COL;
`else
    localparam int DRAIN_LEN = NUM_PROC_COL;
`endif
    localparam int CELL_W = GF_BIT + 2;
    localparam int DCNT_W = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t               state;
    logic [ROW_CNT_W-1:0] remaining;
    logic                 first_row;
    logic [DCNT_W-1:0]    drain_cnt;

    logic accept;
    logic slot_start;
    logic slot_finish;

    assign accept      = (state == STREAM) && row_valid;
    assign slot_start  = accept && first_row;
    assign slot_finish = accept && (remaining == ROW_CNT_W'(1));

    assign cmd_ready = (state == IDLE);
    assign row_ready = (state == STREAM);
    assign busy      = (state != IDLE);

    // A missing row still consumes its slot because the array cannot stall; only accepted rows count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            first_row <= 1'b0;
            drain_cnt <= '0;
            arr_op    <= '0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        arr_op    <= cmd_op;
                        underrun  <= 1'b0;
                        remaining <= cmd_rows;
                        first_row <= 1'b1;
                        drain_cnt <= '0;
                        state     <= (cmd_rows == '0) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (row_valid) begin
                        first_row <= 1'b0;
                        remaining <= remaining - ROW_CNT_W'(1);
                        if (remaining == ROW_CNT_W'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCNT_W'(DRAIN_LEN - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_PROC_COL; c++) begin : g_col
        logic [GF_BIT-1:0] in_data;
        logic [CELL_W-1:0] in_cell;
        logic [CELL_W-1:0] out_cell;

        assign in_data = accept ? row_data[c*GF_BIT +: GF_BIT] : '0;
        assign in_cell = {in_data, slot_start, slot_finish};

        if (c == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (rst) out_cell <= '0;
                else     out_cell <= in_cell;
            end
        end else begin : g_skew
            // Column c sees each row c cycles after column 0, giving the diagonal wavefront.
            logic [CELL_W-1:0] sr [c];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < c; k++) sr[k] <= '0;
                    out_cell <= '0;
                end else begin
                    sr[0] <= in_cell;
                    for (int k = 1; k < c; k++) sr[k] <= sr[k-1];
                    out_cell <= sr[c-1];
                end
            end
        end

        assign arr_data[c*GF_BIT +: GF_BIT] = out_cell[CELL_W-1:2];
        assign arr_start[c]                 = out_cell[1];
        assign arr_finish[c]                = out_cell[0];
    end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: directed table passes, reset abort, and random passes checked
// against a slot-timeline model (row in slot j appears on column c at cycle j+1+c).
module tb_systolic_row_feeder;

    localparam int GF_BIT = 4;
    localparam int NPC    = 3;
    localparam int OPW    = 4;
    localparam int RCW    = 8;
    localparam int RW     = NPC * GF_BIT;
`ifdef FEEDER_FLUSH_EN
    localparam int DRAIN = 2 * NPC;
`else
    localparam int DRAIN = NPC;
`endif
    localparam int EXTRA = DRAIN - NPC;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [RCW-1:0] cmd_rows;
    logic           row_valid;
    logic           row_ready;
    logic [RW-1:0]  row_data;
    logic [RW-1:0]  arr_data;
    logic [NPC-1:0] arr_start;
    logic [NPC-1:0] arr_finish;
    logic [OPW-1:0] arr_op;
    logic           busy;
    logic           done;
    logic           underrun;

    systolic_row_feeder #(
        .GF_BIT(GF_BIT), .NUM_PROC_COL(NPC), .OP_CODE_LEN(OPW), .ROW_CNT_W(RCW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rows(cmd_rows),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .arr_data(arr_data), .arr_start(arr_start), .arr_finish(arr_finish), .arr_op(arr_op),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Slot timeline of one pass, indexed 1..S (slot n is the stream cycle n after the cmd handshake).
    logic [RW-1:0] sd [0:599];
    logic          ss [0:599];
    logic          sf [0:599];
    logic          sg [0:599];

    typedef struct {
        int           rows;
        logic [3:0]   op;
        logic [7:0]   gap_mask;
        logic [47:0]  words;
        int           done_at;
    } vec_t;

    vec_t table_v [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic buildSlots(input int rows, input logic [7:0] gap_mask, input int gap_pct,
                              input logic [47:0] words, output int s);
        int k = 0;
        int i = 0;
        while (k < rows) begin
            logic gap;
            gap = ((i < 8) && gap_mask[i]) || (int'($urandom_range(99)) < gap_pct);
            if (i >= 500) gap = 1'b0;
            i++;
            sg[i] = gap;
            if (gap) begin
                sd[i] = '0; ss[i] = 1'b0; sf[i] = 1'b0;
            end else begin
                sd[i] = (k < 4) ? words[k*RW +: RW] : RW'($urandom);
                ss[i] = (k == 0);
                sf[i] = (k == rows - 1);
                k++;
            end
        end
        s = i;
    endtask

    // Issues the command in the current cycle, then plays the slot timeline and checks every cycle.
    task automatic applyStimulus(input int rows, input logic [3:0] op, input int s, input int done_at);
        int   total;
        logic und;
        total = s + DRAIN + 1;
        und   = 1'b0;
        checkOutput("cmd_ready@0", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rows  = RCW'(rows);
        for (int n = 1; n <= total; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = (n < total) ? 1'($urandom) : 1'b0;
            cmd_op    = OPW'($urandom);
            cmd_rows  = RCW'($urandom);
            if (n <= s) begin
                row_valid = !sg[n];
                row_data  = sg[n] ? RW'($urandom) : sd[n];
            end else begin
                row_valid = 1'($urandom);
                row_data  = RW'($urandom);
            end
            if ((n - 1 >= 1) && (n - 1 <= s) && sg[n-1]) und = 1'b1;
            checkOutput($sformatf("row_ready@%0d", n), 32'(row_ready), 32'(n <= s));
            checkOutput($sformatf("busy@%0d", n), 32'(busy), 32'(n <= s + DRAIN));
            checkOutput($sformatf("done@%0d", n), 32'(done), 32'(n == done_at));
            checkOutput($sformatf("arr_op@%0d", n), 32'(arr_op), 32'(op));
            checkOutput($sformatf("underrun@%0d", n), 32'(underrun), 32'(und));
            for (int c = 0; c < NPC; c++) begin
                int               idx;
                logic [GF_BIT-1:0] ed;
                logic             es;
                logic             ef;
                idx = n - 1 - c;
                if (idx >= 1 && idx <= s) begin
                    ed = sd[idx][c*GF_BIT +: GF_BIT]; es = ss[idx]; ef = sf[idx];
                end else begin
                    ed = '0; es = 1'b0; ef = 1'b0;
                end
                checkOutput($sformatf("data c%0d@%0d", c, n), 32'(arr_data[c*GF_BIT +: GF_BIT]), 32'(ed));
                checkOutput($sformatf("start c%0d@%0d", c, n), 32'(arr_start[c]), 32'(es));
                checkOutput($sformatf("finish c%0d@%0d", c, n), 32'(arr_finish[c]), 32'(ef));
            end
        end
    endtask

    task automatic checkIdleClear(input string tag);
        checkOutput({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, " row_ready"}, 32'(row_ready), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " underrun"}, 32'(underrun), 32'd0);
        checkOutput({tag, " arr_data"}, 32'(arr_data), 32'd0);
        checkOutput({tag, " arr_start"}, 32'(arr_start), 32'd0);
        checkOutput({tag, " arr_finish"}, 32'(arr_finish), 32'd0);
        checkOutput({tag, " arr_op"}, 32'(arr_op), 32'd0);
    endtask

    task automatic runTableEntry(input int t);
        int s;
        buildSlots(table_v[t].rows, table_v[t].gap_mask, 0, table_v[t].words, s);
        applyStimulus(table_v[t].rows, table_v[t].op, s, table_v[t].done_at);
    endtask

    initial begin
        // Directed passes with hand-derived done cycles (cycle 0 = cmd handshake).
        table_v[0] = '{rows: 2, op: 4'h3, gap_mask: 8'h00, words: 48'h000_000_654_321, done_at: 6 + EXTRA};
        table_v[1] = '{rows: 1, op: 4'h5, gap_mask: 8'h00, words: 48'h000_000_000_ABC, done_at: 5 + EXTRA};
        table_v[2] = '{rows: 2, op: 4'h9, gap_mask: 8'h01, words: 48'h000_000_654_321, done_at: 7 + EXTRA};
        table_v[3] = '{rows: 0, op: 4'hE, gap_mask: 8'h00, words: 48'h0,               done_at: 4 + EXTRA};
        table_v[4] = '{rows: 4, op: 4'h1, gap_mask: 8'h05, words: 48'h111_222_333_444, done_at: 10 + EXTRA};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rows = '0; row_valid = 1'b0; row_data = '0;
        @(posedge clk); @(posedge clk); #1;
        checkIdleClear("reset");
        rst = 1'b0;

        for (int t = 0; t < 5; t++) runTableEntry(t);

        // Reset in cycle 3 of a 4-row pass aborts it with no done.
        cmd_valid = 1'b1; cmd_op = 4'h7; cmd_rows = 8'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0; row_valid = 1'b1; row_data = 12'h123;
        @(posedge clk); #1;
        row_data = 12'h456;
        @(posedge clk); #1;
        row_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkIdleClear("abort");
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort no done +%0d", n), 32'(done), 32'd0);
            checkOutput($sformatf("abort idle +%0d", n), 32'(busy), 32'd0);
        end
        runTableEntry(0);

        for (int p = 0; p < 20; p++) begin
            int s;
            int rows;
            rows = int'($urandom_range(12));
            buildSlots(rows, 8'h00, 30, 48'(0), s);
            for (int k = 1; k <= s; k++) if (!sg[k] && ss[k] == 1'b0 && k > 0) sd[k] = RW'($urandom);
            applyStimulus(rows, 4'($urandom), s, s + DRAIN + 1);
        end

        begin
            int s;
            buildSlots(255, 8'h00, 10, 48'hFED_CBA_987_654, s);
            applyStimulus(255, 4'hA, s, s + DRAIN + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
